// File: rtl/mem_stage.sv
// MEM stage of the 5-stage MIPS core.
// Registers the EX->MEM bus, formats synchronous data-SRAM load data,
// selects the register-file write value and drives the MEM->WB and
// MEM->ID forwarding buses. HI/LO fields pass straight through.
//
// Flow control: there is no valid/ready handshake. stall[3] freezes this
// stage; if the downstream stage (stall[4]) is still moving, a zero bubble
// is inserted instead, so the current entry is not handed to WB twice.
// Load data captured on the single "fresh" cycle is kept in a hold register,
// so a stalled load keeps producing the same result for any stall length.
module mem_stage #(
   parameter int IN_WD  = 146,
   parameter int WB_WD  = 137,
   parameter int FWD_WD = 105
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [5:0]        stall,
   input  logic [IN_WD-1:0]  ex_to_mem_bus,
   input  logic [31:0]       data_sram_rdata,
   output logic [WB_WD-1:0]  mem_to_wb_bus,
   output logic [FWD_WD-1:0] mem_to_id_fwd
);

   // Field layout of the EX->MEM bus, MSB first.
   typedef struct packed {
      logic [2:0]  ld_type;
      logic        lo_wen;
      logic        hi_wen;
      logic        hilo_sel;
      logic [63:0] hilo_data;
      logic [31:0] pc;
      logic        ram_en;
      logic [3:0]  ram_wen;
      logic        sel_rf_res;
      logic        rf_we;
      logic [4:0]  rf_waddr;
      logic [31:0] ex_result;
   } ex_bus_t;

   localparam logic [2:0] LD_LW  = 3'b000;
   localparam logic [2:0] LD_LB  = 3'b001;
   localparam logic [2:0] LD_LBU = 3'b010;
   localparam logic [2:0] LD_LH  = 3'b011;
   localparam logic [2:0] LD_LHU = 3'b100;

   logic [IN_WD-1:0] stage_q, stage_d;
   logic             fresh_q, fresh_d;
   logic [31:0]      rdata_hold_q, rdata_hold_d;

   ex_bus_t     cur;
   logic        cur_is_load;
   logic [31:0] rd;
   logic [7:0]  ld_byte;
   logic [15:0] ld_half;
   logic [31:0] ld_fmt;
   logic [31:0] rf_wdata;

   // Only the MEM and WB stall bits matter to this stage.
   logic unused_stall;
   assign unused_stall = ^{stall[5], stall[2:0]};

   assign cur         = ex_bus_t'(stage_q);
   assign cur_is_load = cur.ram_en && (cur.ram_wen == 4'b0000);

   // Next-state selection for the stage register, fresh flag and load hold.
   always_comb begin
      stage_d      = stage_q;
      fresh_d      = 1'b0;
      rdata_hold_d = rdata_hold_q;
      // The SRAM word belongs to this entry only on its fresh cycle.
      if (fresh_q && cur_is_load) begin
         rdata_hold_d = data_sram_rdata;
      end
      if (stall[3] && !stall[4]) begin
         stage_d = '0;
      end else if (stall[3] && stall[4]) begin
         stage_d = stage_q;
      end else begin
         stage_d = ex_to_mem_bus;
         fresh_d = 1'b1;
      end
   end

   // State registers with synchronous active-high reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         stage_q      <= '0;
         fresh_q      <= 1'b0;
         rdata_hold_q <= '0;
      end else begin
         stage_q      <= stage_d;
         fresh_q      <= fresh_d;
         rdata_hold_q <= rdata_hold_d;
      end
   end

   // Pick the addressed byte/halfword lane (little-endian) from the read word.
   always_comb begin
      rd = fresh_q ? data_sram_rdata : rdata_hold_q;
      ld_byte = rd[7:0];
      case (cur.ex_result[1:0])
         2'd0:    ld_byte = rd[7:0];
         2'd1:    ld_byte = rd[15:8];
         2'd2:    ld_byte = rd[23:16];
         default: ld_byte = rd[31:24];
      endcase
      ld_half = cur.ex_result[1] ? rd[31:16] : rd[15:0];
   end

   // Extend the selected lane per load type; unknown types behave as LW.
   always_comb begin
      ld_fmt = rd;
      case (cur.ld_type)
         LD_LW:   ld_fmt = rd;
         LD_LB:   ld_fmt = {{24{ld_byte[7]}}, ld_byte};
         LD_LBU:  ld_fmt = {24'd0, ld_byte};
         LD_LH:   ld_fmt = {{16{ld_half[15]}}, ld_half};
         LD_LHU:  ld_fmt = {16'd0, ld_half};
         default: ld_fmt = rd;
      endcase
   end

   // Register-file write value and the two outgoing buses.
   always_comb begin
      rf_wdata = cur.sel_rf_res ? ld_fmt : cur.ex_result;
      mem_to_wb_bus = {cur.lo_wen, cur.hi_wen, cur.hilo_sel, cur.hilo_data, cur.pc,
                       cur.rf_we, cur.rf_waddr, rf_wdata};
      mem_to_id_fwd = {cur.lo_wen, cur.hi_wen, cur.hilo_sel, cur.hilo_data,
                       cur.rf_we, cur.rf_waddr, rf_wdata};
   end

endmodule

// File: tb/tb_mem_stage.sv
// Testbench for mem_stage: directed vector table, stall/bubble sequences and
// randomized traffic checked against a transaction-level reference model.
module tb_mem_stage;

   typedef struct packed {
      logic [2:0]  ld_type;
      logic        lo_wen;
      logic        hi_wen;
      logic        hilo_sel;
      logic [63:0] hilo_data;
      logic [31:0] pc;
      logic        ram_en;
      logic [3:0]  ram_wen;
      logic        sel_rf_res;
      logic        rf_we;
      logic [4:0]  rf_waddr;
      logic [31:0] ex_result;
   } ex_t;

   typedef struct {
      logic [5:0]  stall;
      ex_t         ex;
      logic [31:0] rdata;
      bit          chk;
      logic        we;
      logic [4:0]  waddr;
      logic [31:0] wdata;
      logic        hi;
      logic        lo;
      string       name;
   } vec_t;

   // ---------------- clock / reset / DUT ----------------
   logic         clk = 1'b0;
   logic         rst;
   logic [5:0]   stall;
   logic [145:0] ex_to_mem_bus;
   logic [31:0]  data_sram_rdata;
   logic [136:0] mem_to_wb_bus;
   logic [104:0] mem_to_id_fwd;

   always #5 clk = ~clk;

   mem_stage dut (
      .clk             (clk),
      .rst             (rst),
      .stall           (stall),
      .ex_to_mem_bus   (ex_to_mem_bus),
      .data_sram_rdata (data_sram_rdata),
      .mem_to_wb_bus   (mem_to_wb_bus),
      .mem_to_id_fwd   (mem_to_id_fwd)
   );

   int vectors     = 0;
   int miscompares = 0;

   // ---------------- reference model ----------------
   // The model tracks which instruction occupies MEM, whether this is its
   // first cycle there, and the SRAM word that was returned for it.
   ex_t         m_e;
   bit          m_first = 1'b0;
   logic [31:0] m_word;
   bit          m_valid = 1'b0;

   function automatic logic [31:0] fmt_load(input logic [2:0] t, input logic [1:0] a,
                                            input logic [31:0] w);
      int unsigned b;
      int unsigned h;
      b = (w >> (8 * a)) & 32'hFF;
      h = (w >> (16 * a[1])) & 32'hFFFF;
      case (t)
         3'd1:    return (b >= 128) ? (b | 32'hFFFFFF00) : b;
         3'd2:    return b;
         3'd3:    return (h >= 32768) ? (h | 32'hFFFF0000) : h;
         3'd4:    return h;
         default: return w;
      endcase
   endfunction

   function automatic logic [31:0] model_wdata();
      logic [31:0] word;
      word = m_first ? data_sram_rdata : m_word;
      if (m_e.sel_rf_res) return fmt_load(m_e.ld_type, m_e.ex_result[1:0], word);
      return m_e.ex_result;
   endfunction

   function automatic logic [136:0] model_wb();
      return {m_e.lo_wen, m_e.hi_wen, m_e.hilo_sel, m_e.hilo_data, m_e.pc,
              m_e.rf_we, m_e.rf_waddr, model_wdata()};
   endfunction

   function automatic logic [104:0] model_fwd();
      return {m_e.lo_wen, m_e.hi_wen, m_e.hilo_sel, m_e.hilo_data,
              m_e.rf_we, m_e.rf_waddr, model_wdata()};
   endfunction

   // ---------------- scoreboard compare ----------------
   task automatic chk(input string name, input logic [136:0] act, input logic [136:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic apply(input logic r, input logic [5:0] st, input ex_t e, input logic [31:0] rd);
      rst             = r;
      stall           = st;
      ex_to_mem_bus   = e;
      data_sram_rdata = rd;
      #1;
      if (m_valid) begin
         chk("model_wb", mem_to_wb_bus, model_wb());
         chk("model_fwd", 137'(mem_to_id_fwd), 137'(model_fwd()));
      end
   endtask

   task automatic advance();
      @(posedge clk);
      if (rst) begin
         m_e     = '0;
         m_first = 1'b0;
         m_word  = '0;
         m_valid = 1'b1;
      end else begin
         if (m_first) m_word = data_sram_rdata;
         if (stall[3] && !stall[4]) begin
            m_e     = '0;
            m_first = 1'b0;
         end else if (stall[3]) begin
            m_first = 1'b0;
         end else begin
            m_e     = ex_t'(ex_to_mem_bus);
            m_first = 1'b1;
         end
      end
      @(negedge clk);
   endtask

   // ---------------- instruction builders ----------------
   function automatic ex_t ld(input logic [2:0] t, input logic [31:0] addr, input logic [4:0] wa);
      ex_t e = '0;
      e.ld_type = t;  e.pc = 32'hBFC0_0100;
      e.ram_en = 1'b1;  e.sel_rf_res = 1'b1;  e.rf_we = 1'b1;
      e.rf_waddr = wa;  e.ex_result = addr;
      return e;
   endfunction

   function automatic ex_t alu(input logic [4:0] wa, input logic [31:0] res);
      ex_t e = '0;
      e.pc = 32'hBFC0_0200;  e.rf_we = 1'b1;  e.rf_waddr = wa;  e.ex_result = res;
      return e;
   endfunction

   function automatic ex_t mthi(input logic [31:0] v);
      ex_t e = '0;
      e.pc = 32'hBFC0_0300;  e.hi_wen = 1'b1;  e.hilo_sel = 1'b1;
      e.hilo_data = {v, 32'h0};  e.ex_result = v;
      return e;
   endfunction

   function automatic ex_t store(input logic [31:0] addr);
      ex_t e = '0;
      e.pc = 32'hBFC0_0400;  e.ram_en = 1'b1;  e.ram_wen = 4'hF;  e.ex_result = addr;
      return e;
   endfunction

   function automatic ex_t rand_ex();
      ex_t e = '0;
      int  kind;
      kind = $urandom_range(0, 4);
      e.pc = $urandom;
      e.rf_waddr = 5'($urandom);
      e.ex_result = $urandom;
      case (kind)
         0, 1: begin
            e.ld_type = 3'($urandom_range(0, 7));
            e.ram_en = 1'b1;  e.sel_rf_res = 1'b1;  e.rf_we = 1'b1;
         end
         2: begin
            e.ram_en = 1'b1;  e.ram_wen = 4'($urandom_range(1, 15));
         end
         3: e.rf_we = 1'($urandom_range(0, 1));
         default: begin
            e.hi_wen = 1'($urandom_range(0, 1));
            e.lo_wen = 1'($urandom_range(0, 1));
            e.hilo_sel = 1'($urandom_range(0, 1));
            e.hilo_data = {$urandom, $urandom};
         end
      endcase
      return e;
   endfunction

   vec_t vq[$];

   task automatic add(input logic [5:0] st, input ex_t e, input logic [31:0] rd, input bit c,
                      input logic we, input logic [4:0] wa, input logic [31:0] wd,
                      input logic hi, input logic lo, input string name);
      vec_t v;
      v.stall = st;  v.ex = e;  v.rdata = rd;  v.chk = c;
      v.we = we;  v.waddr = wa;  v.wdata = wd;  v.hi = hi;  v.lo = lo;  v.name = name;
      vq.push_back(v);
   endtask

   // ---------------- main test ----------------
   initial begin
      ex_t nop;
      nop = '0;

      // Reset with random inputs: every output bit must be zero.
      apply(1'b1, 6'($urandom), rand_ex(), $urandom);
      advance();
      for (int i = 0; i < 2; i++) begin
         apply(1'b1, 6'($urandom), rand_ex(), $urandom);
         chk("rst_wb", mem_to_wb_bus, 137'd0);
         chk("rst_fwd", 137'(mem_to_id_fwd), 137'd0);
         advance();
      end

      // Each row: inputs for one cycle, and the outputs expected in that cycle.
      add(6'o00, ld(3'd0, 32'h10, 5'd5),  32'h0,        0, 0, 0,  32'h0,        0, 0, "issue_lw");
      add(6'o00, ld(3'd1, 32'h13, 5'd6),  32'hDEADBEEF, 1, 1, 5,  32'hDEADBEEF, 0, 0, "lw");
      add(6'o00, ld(3'd2, 32'h13, 5'd7),  32'h80FF7F01, 1, 1, 6,  32'hFFFFFF80, 0, 0, "lb");
      add(6'o00, ld(3'd3, 32'h12, 5'd8),  32'h80FF7F01, 1, 1, 7,  32'h00000080, 0, 0, "lbu");
      add(6'o00, ld(3'd4, 32'h12, 5'd9),  32'h8001ABCD, 1, 1, 8,  32'hFFFF8001, 0, 0, "lh");
      add(6'o00, ld(3'd0, 32'h20, 5'd10), 32'h8001ABCD, 1, 1, 9,  32'h00008001, 0, 0, "lhu");
      add(6'o30, alu(5'd1, 32'h1),        32'h11223344, 1, 1, 10, 32'h11223344, 0, 0, "lw_fresh");
      add(6'o30, alu(5'd1, 32'h1),        32'h0,        1, 1, 10, 32'h11223344, 0, 0, "hold1");
      add(6'o30, alu(5'd1, 32'h1),        32'h0,        1, 1, 10, 32'h11223344, 0, 0, "hold2");
      add(6'o00, mthi(32'h12345678),      32'h0,        1, 1, 10, 32'h11223344, 0, 0, "hold3");
      add(6'o10, alu(5'd3, 32'hCAFEF00D), 32'h0BADF00D, 1, 0, 0,  32'h12345678, 1, 0, "mthi_fwd");
      add(6'o00, alu(5'd3, 32'hCAFEF00D), 32'h0,        1, 0, 0,  32'h0,        0, 0, "bubble");
      add(6'o30, ld(3'd0, 32'h40, 5'd12), 32'h0,        1, 1, 3,  32'hCAFEF00D, 0, 0, "alu");
      add(6'o00, ld(3'd0, 32'h40, 5'd12), 32'h77777777, 1, 1, 3,  32'hCAFEF00D, 0, 0, "alu_held");
      add(6'o00, nop,                     32'h55AA55AA, 1, 1, 12, 32'h55AA55AA, 0, 0, "release_fresh");
      add(6'o20, ld(3'd2, 32'h11, 5'd13), 32'h12345678, 1, 0, 0,  32'h0,        0, 0, "nop");
      add(6'o00, nop,                     32'hA1B2C3D4, 1, 1, 13, 32'h000000C3, 0, 0, "lbu_lane1");
      add(6'o00, store(32'h44),           32'h0,        1, 0, 0,  32'h0,        0, 0, "nop2");
      add(6'o00, nop,                     32'hFFFFFFFF, 1, 0, 0,  32'h00000044, 0, 0, "store");

      foreach (vq[i]) begin
         apply(1'b0, vq[i].stall, vq[i].ex, vq[i].rdata);
         if (vq[i].chk) begin
            chk({vq[i].name, "_we"},    137'(mem_to_wb_bus[37]),     137'(vq[i].we));
            chk({vq[i].name, "_waddr"}, 137'(mem_to_wb_bus[36:32]),  137'(vq[i].waddr));
            chk({vq[i].name, "_wdata"}, 137'(mem_to_wb_bus[31:0]),   137'(vq[i].wdata));
            chk({vq[i].name, "_hi"},    137'(mem_to_wb_bus[135]),    137'(vq[i].hi));
            chk({vq[i].name, "_lo"},    137'(mem_to_wb_bus[136]),    137'(vq[i].lo));
            chk({vq[i].name, "_fwd_we"},    137'(mem_to_id_fwd[37]),   137'(vq[i].we));
            chk({vq[i].name, "_fwd_hi"},    137'(mem_to_id_fwd[103]),  137'(vq[i].hi));
            chk({vq[i].name, "_fwd_wdata"}, 137'(mem_to_id_fwd[31:0]), 137'(vq[i].wdata));
         end
         advance();
      end

      // Randomized traffic with random stalls, bubbles and occasional resets.
      for (int i = 0; i < 500; i++) begin
         int          s;
         logic [1:0]  s43;
         logic        r;
         s = $urandom_range(0, 9);
         if (s < 6)       s43 = 2'b00;
         else if (s < 8)  s43 = 2'b11;
         else if (s == 8) s43 = 2'b01;
         else             s43 = 2'b10;
         r = ($urandom_range(0, 59) == 0);
         apply(r, {1'($urandom), s43, 3'($urandom)}, rand_ex(), $urandom);
         advance();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
